// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative RV32M multiply/divide unit, one result bit per cycle
module muldiv_unit #(
   parameter  int XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   acc_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   addend_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic              is_div, is_rem, neg_in;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   mag_a, mag_b, special_val;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   dq_sel, dq_fix, fix_val;

   // Accept-side decode: sign handling and the ops that never enter RUN
   always_comb begin
      accept   = start && (state_q == S_IDLE || state_q == S_DONE);
      a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg    = a_signed && operand_a[XLEN-1];
      b_neg    = b_signed && operand_b[XLEN-1];
      mag_a    = a_neg ? -operand_a : operand_a;
      mag_b    = b_neg ? -operand_b : operand_b;
      is_div   = funct3[2];
      is_rem   = funct3[2] && funct3[1];
      neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
      div_zero = is_div && (operand_b == '0);
      div_ovf  = is_div && !funct3[0] && (operand_a == INT_MIN) && (operand_b == '1);
      special  = div_zero || div_ovf;
      if (div_zero)
         special_val = funct3[1] ? operand_a : '1;
      else
         special_val = funct3[1] ? '0 : operand_a;
   end

   // Shared datapath: {acc, lo} is the product for multiply, {remainder, quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, acc_q} + ({1'b0, addend_q} & {(XLEN+1){lo_q[0]}});
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, addend_q};
      prod_fix  = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
      dq_sel    = op_q[1] ? acc_q : lo_q;
      dq_fix    = neg_q ? -dq_sel : dq_sel;
      if (op_q[2])
         fix_val = dq_fix;
      else if (op_q == 3'b000)
         fix_val = prod_fix[XLEN-1:0];
      else
         fix_val = prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = special ? S_DONE : S_RUN;
         S_RUN: begin
            if (abort)
               state_d = S_IDLE;
            else if (cnt_q == CNT_ONE)
               state_d = S_FIX;
         end
         S_FIX:   state_d = abort ? S_IDLE : S_DONE;
         S_DONE:  state_d = accept ? (special ? S_DONE : S_RUN) : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         lo_q     <= '0;
         addend_q <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q   <= funct3;
                  neg_q  <= neg_in;
                  cnt_q  <= CNT_INIT;
                  acc_q  <= '0;
                  if (is_div) begin
                     lo_q     <= mag_a;
                     addend_q <= mag_b;
                  end else begin
                     lo_q     <= mag_b;
                     addend_q <= mag_a;
                  end
                  if (special)
                     result_q <= special_val;
               end
            end
            S_RUN: begin
               if (!abort) begin
                  cnt_q <= cnt_q - CNT_ONE;
                  if (op_q[2]) begin
                     if (!div_diff[XLEN]) begin
                        acc_q <= div_diff[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], 1'b1};
                     end else begin
                        acc_q <= div_shift[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], 1'b0};
                     end
                  end else begin
                     acc_q <= mul_sum[XLEN:1];
                     lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!abort)
                  result_q <= fix_val;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule
